// File: rtl/clk_sched_pkg.sv
// clk_sched_pkg: layer-state codes, scheduler state encoding and counter width shared by the clock scheduler.
package clk_sched_pkg;
    localparam int IDLE_STATE      = 1;
    localparam int CONV1_1_CODE    = 2;
    localparam int CONV1_2_CODE    = 3;
    localparam int AVG_POOL1_STATE = 4;
    localparam int CONV2_1_CODE    = 5;
    localparam int CONV2_2_CODE    = 6;
    localparam int AVG_POOL2_STATE = 7;
    localparam int CONV3_1_CODE    = 8;
    localparam int CONV3_2_CODE    = 9;
    localparam int CNT_W           = 4;
    typedef enum logic [1:0] {
        SLOW          = 2'd0,
        DRAIN_TO_FAST = 2'd1,
        FAST          = 2'd2,
        DRAIN_TO_SLOW = 2'd3
    } sched_state_t;
endpackage

// File: rtl/ce_divider.sv
// ce_divider: slow-rate enable divider; tick marks the last count of each SLOW_DIV period while running.
module ce_divider
    import clk_sched_pkg::*;
#(
    parameter int SLOW_DIV = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic tick,
    output logic at_boundary
);
    logic [CNT_W-1:0] cnt;
    // Compare with >= so a count can never run past the terminal value.
    assign at_boundary = cnt >= CNT_W'(SLOW_DIV - 1);
    assign tick = run && !clear && at_boundary;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt <= '0;
        else cnt <= clear ? '0 : !run ? cnt : at_boundary ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/clk_rate_scheduler.sv
// clk_rate_scheduler: registered datapath clock-enable, full rate in conv layers and 1/SLOW_DIV otherwise,
// with a drain window on every rate switch; CLK_SCHED_STATS_EN adds a saturating switch_count.
module clk_rate_scheduler
    import clk_sched_pkg::*;
#(
    parameter int STATE_DATAWIDTH = 4,
    parameter int CONV1_1_STATE   = CONV1_1_CODE,
    parameter int CONV1_2_STATE   = CONV1_2_CODE,
    parameter int CONV2_1_STATE   = CONV2_1_CODE,
    parameter int CONV2_2_STATE   = CONV2_2_CODE,
    parameter int CONV3_1_STATE   = CONV3_1_CODE,
    parameter int CONV3_2_STATE   = CONV3_2_CODE,
    parameter int SLOW_DIV        = 3,
    parameter int DRAIN_CYCLES    = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [STATE_DATAWIDTH-1:0] State,
    input  logic                       PS_BRAM_busy,
    output logic                       ce_out,
    output logic                       fast_mode,
`ifdef CLK_SCHED_STATS_EN
    output logic [15:0]                switch_count,
`endif
    output logic                       switch_busy
);
    sched_state_t     st;
    logic [CNT_W-1:0] dcnt;
    logic             is_conv, tick, at_boundary, drain, drain_end;

    assign is_conv = State == STATE_DATAWIDTH'(CONV1_1_STATE) || State == STATE_DATAWIDTH'(CONV1_2_STATE)
                  || State == STATE_DATAWIDTH'(CONV2_1_STATE) || State == STATE_DATAWIDTH'(CONV2_2_STATE)
                  || State == STATE_DATAWIDTH'(CONV3_1_STATE) || State == STATE_DATAWIDTH'(CONV3_2_STATE);
    assign drain = st == DRAIN_TO_FAST || st == DRAIN_TO_SLOW;
    assign drain_end = drain && dcnt >= CNT_W'(DRAIN_CYCLES - 1);

    ce_divider #(.SLOW_DIV(SLOW_DIV)) u_div (
        .clk        (clk),
        .reset      (reset),
        .clear      (st != SLOW),
        .run        (st == SLOW),
        .tick       (tick),
        .at_boundary(at_boundary)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st          <= SLOW;
            dcnt        <= '0;
            ce_out      <= 1'b0;
            fast_mode   <= 1'b0;
            switch_busy <= 1'b0;
        end else begin
            ce_out      <= st == FAST || tick;
            fast_mode   <= st == FAST;
            switch_busy <= drain;
            dcnt        <= drain && !drain_end ? dcnt + 1'b1 : '0;
            case (st)
                SLOW:          if (st == SLOW && at_boundary && is_conv && !PS_BRAM_busy) st <= DRAIN_TO_FAST;
                DRAIN_TO_FAST: if (drain_end) st <= is_conv ? FAST : SLOW;
                FAST:          if (!is_conv) st <= DRAIN_TO_SLOW;
                DRAIN_TO_SLOW: if (drain_end) st <= SLOW;
            endcase
        end
    end

`ifdef CLK_SCHED_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) switch_count <= '0;
        else if (drain_end && switch_count != 16'hFFFF) switch_count <= switch_count + 1'b1;
    end
`endif
endmodule

// File: tb/tb_clk_rate_scheduler.sv
// tb_clk_rate_scheduler: directed and randomized stimulus checked against a behavioural rate model.
module tb_clk_rate_scheduler;
    localparam int SD = 3;
    localparam int DC = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       PS_BRAM_busy = 1'b0;
    logic [3:0] State = 4'd0;
    logic       ce_out, fast_mode, switch_busy;
`ifdef CLK_SCHED_STATS_EN
    logic [15:0] switch_count;
`endif

    int errors = 0;
    int checks = 0;
    int mode = 0;
    int drain_left = 0;
    int slow_n = 0;
    int sw = 0;
    bit to_fast = 1'b0;
    bit e_ce = 1'b0, e_fast = 1'b0, e_busy = 1'b0;

    always #5 clk = ~clk;

    clk_rate_scheduler #(.SLOW_DIV(SD), .DRAIN_CYCLES(DC)) dut (
        .clk         (clk),
        .reset       (reset),
        .State       (State),
        .PS_BRAM_busy(PS_BRAM_busy),
        .ce_out      (ce_out),
        .fast_mode   (fast_mode),
`ifdef CLK_SCHED_STATS_EN
        .switch_count(switch_count),
`endif
        .switch_busy (switch_busy)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    function automatic bit conv(input logic [3:0] s);
        return s inside {4'd2, 4'd3, 4'd5, 4'd6, 4'd8, 4'd9};
    endfunction

    // mode: 0 slow rate, 1 draining, 2 full rate; slow_n counts cycles since entering slow rate
    task automatic model_reset();
        mode = 0; slow_n = 0; drain_left = 0; sw = 0;
        e_ce = 0; e_fast = 0; e_busy = 0;
    endtask

    task automatic model_step(input bit c, input bit b);
        e_ce = 0; e_fast = 0; e_busy = 0;
        if (mode == 0) begin
            e_ce = (slow_n % SD) == SD - 1;
            if (e_ce && c && !b) begin mode = 1; to_fast = 1; drain_left = DC; end
            else slow_n++;
        end else if (mode == 1) begin
            e_busy = 1;
            drain_left--;
            if (drain_left == 0) begin
                if (sw < 65535) sw++;
                if (to_fast && c) mode = 2;
                else begin mode = 0; slow_n = 0; end
            end
        end else begin
            e_ce = 1; e_fast = 1;
            if (!c) begin mode = 1; to_fast = 0; drain_left = DC; end
        end
    endtask

    task automatic compare();
        check("ce_out", int'(ce_out), int'(e_ce));
        check("fast_mode", int'(fast_mode), int'(e_fast));
        check("switch_busy", int'(switch_busy), int'(e_busy));
`ifdef CLK_SCHED_STATS_EN
        check("switch_count", int'(switch_count), sw);
`endif
    endtask

    task automatic cyc(input logic [3:0] s, input bit b);
        State = s;
        PS_BRAM_busy = b;
        model_step(conv(s), b);
        @(negedge clk);
        compare();
    endtask

    initial begin
        logic [3:0] s;
        bit b;
        bit hit;
        s = 4'd1;
        b = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        compare();
        reset = 1'b1;
        repeat (30) cyc(4'd1, 1'b0);
        repeat (15) cyc(4'd2, 1'b0);
        repeat (3) cyc(4'd3, 1'b0);
        repeat (15) cyc(4'd4, 1'b0);
        repeat (9) cyc(4'd2, 1'b1);
        repeat (15) cyc(4'd2, 1'b0);
        check("fast_before_abort", int'(fast_mode), 1);
        repeat (3) cyc(4'd4, 1'b0);
        check("in_drain_to_slow", int'(switch_busy), 1);
        #2 reset = 1'b0;
        #1;
        model_reset();
        compare();
        @(negedge clk);
        compare();
        reset = 1'b1;
        repeat (6) cyc(4'd1, 1'b0);
        hit = 1'b0;
        for (int i = 0; i < 12 && !hit; i++) begin
            cyc(4'd2, 1'b0);
            hit = mode == 1 && to_fast && drain_left == DC - 2;
        end
        check("dtf_reached", int'(hit), 1);
        repeat (10) cyc(4'd7, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) s = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) b = ~b;
            cyc(s, b);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
